// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: IO-space bus slave with output/input/bidirectional GPIO registers and an N-chip-select SPI sequencer.
// Define IO_BUS_IRQ_EN to build the GPIO rising-edge interrupt block (IRQ_EN/IRQ_PEND at 0C/0D and irq).
module io_bus_ctrl #(
    parameter int OUT_WIDTH   = 4,
    parameter int IN_WIDTH    = 6,
    parameter int GPIO_WIDTH  = 5,
    parameter int NUM_CS      = 4,
    parameter int SPI_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [7:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic [OUT_WIDTH-1:0]  outputs,
    input  logic [IN_WIDTH-1:0]   inputs,
    output logic [GPIO_WIDTH-1:0] io_dir,
    output logic [GPIO_WIDTH-1:0] io_out,
    input  logic [GPIO_WIDTH-1:0] io_in,
    output logic                  spi_start,
    output logic [7:0]            spi_tx,
    input  logic                  spi_done,
    input  logic [7:0]            spi_rx,
    output logic [NUM_CS-1:0]     spi_cs_n,
    output logic                  irq,
    output logic [1:0]            dbg_state
);
    // Handshake: the master raises req and holds it; done rises one cycle after the
    // access (or when the SPI transfer ends) and holds until req is sampled low.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_SPI_WAIT = 2'd2} state_t;
    localparam int CW = $clog2(SPI_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [31:0]           rdata_q, rdata_d, rd_val;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic [IN_WIDTH-1:0]   in_q;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d, gpio_in_q, gpio_out_q, gpio_out_d;
    logic [7:0]            tx_q, tx_d, rx_q, rx_d;
    logic                  timeout_q, timeout_d, bad_cs_q, bad_cs_d, start_q, start_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  unused_wdata;

`ifdef IO_BUS_IRQ_EN
    logic [GPIO_WIDTH-1:0] prev_q, irq_en_q, irq_en_d, pend_q, pend_d, pend_clr;
    logic                  irq_q;
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            8'h00: rd_val[OUT_WIDTH-1:0]  = out_q;
            8'h01: rd_val[IN_WIDTH-1:0]   = in_q;
            8'h02: rd_val[GPIO_WIDTH-1:0] = dir_q;
            8'h03: rd_val[GPIO_WIDTH-1:0] = gpio_in_q;
            8'h04: rd_val[GPIO_WIDTH-1:0] = gpio_out_q;
            8'h06: rd_val[2:0]            = {bad_cs_q, timeout_q, state_q == S_SPI_WAIT};
            8'h07: rd_val[7:0]            = tx_q;
            8'h08: rd_val[7:0]            = rx_q;
`ifdef IO_BUS_IRQ_EN
            8'h0C: rd_val[GPIO_WIDTH-1:0] = irq_en_q;
            8'h0D: rd_val[GPIO_WIDTH-1:0] = pend_q;
`endif
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        out_d      = out_q;
        dir_d      = dir_q;
        gpio_out_d = gpio_out_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        timeout_d  = timeout_q;
        bad_cs_d   = bad_cs_q;
        start_d    = 1'b0;
        cnt_d      = cnt_q;
        cs_n_d     = cs_n_q;
`ifdef IO_BUS_IRQ_EN
        irq_en_d   = irq_en_q;
        pend_clr   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_DONE;
                    rdata_d = we ? 32'd0 : rd_val;
                    if (we) begin
                        case (addr)
                            8'h00: out_d      = wdata[OUT_WIDTH-1:0];
                            8'h02: dir_d      = wdata[GPIO_WIDTH-1:0];
                            8'h04: gpio_out_d = wdata[GPIO_WIDTH-1:0] & dir_q;
                            8'h05: begin
                                if (wdata[0]) begin
                                    if ({29'd0, wdata[3:1]} < 32'(NUM_CS)) begin
                                        state_d   = S_SPI_WAIT;
                                        timeout_d = 1'b0;
                                        bad_cs_d  = 1'b0;
                                        start_d   = 1'b1;
                                        cnt_d     = CW'(SPI_TIMEOUT);
                                        for (int i = 0; i < NUM_CS; i++)
                                            cs_n_d[i] = (wdata[3:1] != 3'(i));
                                    end else begin
                                        bad_cs_d = 1'b1;
                                    end
                                end
                            end
                            8'h07: tx_d = wdata[7:0];
`ifdef IO_BUS_IRQ_EN
                            8'h0C: irq_en_d = wdata[GPIO_WIDTH-1:0];
                            8'h0D: pend_clr = wdata[GPIO_WIDTH-1:0];
`endif
                            default: ;
                        endcase
                    end
                end
            end
            S_SPI_WAIT: begin
                // A master that dropped req mid-transfer gets no done pulse.
                if (spi_done) begin
                    rx_d    = spi_rx;
                    cs_n_d  = '1;
                    state_d = req ? S_DONE : S_IDLE;
                end else if (cnt_q == CW'(1)) begin
                    timeout_d = 1'b1;
                    cs_n_d    = '1;
                    state_d   = req ? S_DONE : S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef IO_BUS_IRQ_EN
        // A new edge wins over a write-1-to-clear in the same cycle.
        pend_d = (pend_q & ~pend_clr) | (gpio_in_q & ~prev_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rdata_q    <= '0;
            out_q      <= '0;
            in_q       <= '0;
            dir_q      <= '0;
            gpio_in_q  <= '0;
            gpio_out_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            timeout_q  <= 1'b0;
            bad_cs_q   <= 1'b0;
            start_q    <= 1'b0;
            cnt_q      <= '0;
            cs_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            out_q      <= out_d;
            in_q       <= inputs;
            dir_q      <= dir_d;
            gpio_in_q  <= io_in & ~dir_q;
            gpio_out_q <= gpio_out_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            timeout_q  <= timeout_d;
            bad_cs_q   <= bad_cs_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            cs_n_q     <= cs_n_d;
        end
    end

`ifdef IO_BUS_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            irq_en_q <= '0;
            pend_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            prev_q   <= gpio_in_q;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            irq_q    <= |(pend_q & irq_en_q);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign unused_wdata = ^wdata;
    assign rdata     = rdata_q;
    assign done      = (state_q == S_DONE);
    assign outputs   = out_q;
    assign io_dir    = dir_q;
    assign io_out    = gpio_out_q;
    assign spi_start = start_q;
    assign spi_tx    = tx_q;
    assign spi_cs_n  = cs_n_q;
    assign dbg_state = state_q;
endmodule
